// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, the full-width result record and the
// reference compute function used by both the RTL and the UVM model.
package alu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    SHL   = 3'd5,
    SHR   = 3'd6,
    PASSA = 3'd7
  } op_e;

  // Sized for the widest supported operand; consumers narrow result to WIDTH.
  typedef struct packed {
    logic [MAX_W-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
  } alu_res_t;

  // Bit n of v, with n given as a run-time integer.
  function automatic logic bit_at(input logic [MAX_W:0] v, input int unsigned n);
    logic [MAX_W:0] t;
    t = v >> n;
    return t[0];
  endfunction

  // Operands are taken modulo 2^width; result is masked back to width bits.
  function automatic alu_res_t alu_compute(input op_e op,
                                           input logic [MAX_W-1:0] a,
                                           input logic [MAX_W-1:0] b,
                                           input int unsigned width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] am;
    logic [MAX_W-1:0] bm;
    logic [MAX_W-1:0] sh;
    logic [MAX_W-1:0] r;
    logic [MAX_W:0]   wide;
    logic             sa;
    logic             sb;
    logic             sr;
    alu_res_t         res;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    am   = a & mask;
    bm   = b & mask;
    sh   = bm & ((MAX_W'(1) << $clog2(width)) - MAX_W'(1));
    res  = '0;
    wide = '0;
    case (op)
      ADD: begin
        wide      = {1'b0, am} + {1'b0, bm};
        r         = wide[MAX_W-1:0] & mask;
        res.carry = bit_at(wide, width);
      end
      SUB: begin
        r         = (am - bm) & mask;
        res.carry = (am < bm);
      end
      AND:     r = am & bm;
      OR:      r = am | bm;
      XOR:     r = am ^ bm;
      SHL:     r = (am << sh) & mask;
      SHR:     r = am >> sh;
      default: r = am;
    endcase
    sa = bit_at({1'b0, am}, width - 1);
    sb = bit_at({1'b0, bm}, width - 1);
    sr = bit_at({1'b0, r},  width - 1);
    if (op == ADD)      res.overflow = (sa == sb) && (sr != sa);
    else if (op == SUB) res.overflow = (sa != sb) && (sr != sa);
    res.result = r;
    res.zero   = (r == '0);
    return res;
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One valid/ready register slice; ready passes through combinationally.
module alu_pipe_stage
  import alu_pkg::*;
#(
  parameter type data_t = alu_res_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  data_t in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output data_t out_data
);

  logic  valid_q, valid_d;
  data_t data_q,  data_d;

  // Accept when empty or when the held beat leaves this cycle.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_ready && in_valid) ? in_data : data_q;
  end

  // Slice registers, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: compute on input, STAGES register slices, completion counter.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic [CNT_W-1:0] done_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
  } res_t;

  alu_res_t    full;
  res_t        pipe_data [STAGES+1];
  logic [STAGES:0] pipe_valid;
  logic [STAGES:0] pipe_ready;
  logic [CNT_W-1:0] count_q, count_d;

  // Compute at full width then narrow; zero is taken from the full (masked)
  // result, which equals the narrowed one.
  always_comb begin
    full                = alu_compute(op_e'(in_op), MAX_W'(in_a), MAX_W'(in_b), WIDTH);
    pipe_data[0].result   = full.result[WIDTH-1:0];
    pipe_data[0].carry    = full.carry;
    pipe_data[0].overflow = full.overflow;
    pipe_data[0].zero     = (full.result == '0);
  end

  assign pipe_valid[0]      = in_valid;
  assign in_ready           = pipe_ready[0];
  assign pipe_ready[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    alu_pipe_stage #(.data_t(res_t)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (pipe_valid[i]),
      .in_ready  (pipe_ready[i]),
      .in_data   (pipe_data[i]),
      .out_valid (pipe_valid[i+1]),
      .out_ready (pipe_ready[i+1]),
      .out_data  (pipe_data[i+1])
    );
  end

  assign out_valid    = pipe_valid[STAGES];
  assign out_result   = pipe_data[STAGES].result;
  assign out_carry    = pipe_data[STAGES].carry;
  assign out_overflow = pipe_data[STAGES].overflow;
  assign out_zero     = pipe_data[STAGES].zero;

  // Count output transfers, wrapping naturally at 2^CNT_W.
  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready) count_d = count_q + CNT_W'(1);
  end

  // Completion counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign done_count = count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8, STAGES=2, CNT_W=16).
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic          out_carry;
  logic          out_overflow;
  logic          out_zero;
  logic [CW-1:0] done_count;

  alu_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .done_count   (done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int result;
    bit carry;
    bit ovf;
    bit zero;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          model_done = 0;
  bit          rnd_ready = 0;
  bit          prev_stall = 0;
  logic [10:0] prev_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Plain-integer reference: two's complement ranges decide overflow.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int sa, sb, ss, s;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    e = '{0, 0, 0, 0};
    case (op)
      0: begin
        s = a + b; e.result = s % 256; e.carry = (s > 255);
        ss = sa + sb; e.ovf = (ss > 127) || (ss < -128);
      end
      1: begin
        s = a - b; e.result = (s + 256) % 256; e.carry = (a < b);
        ss = sa - sb; e.ovf = (ss > 127) || (ss < -128);
      end
      2: e.result = a & b;
      3: e.result = a | b;
      4: e.result = a ^ b;
      5: e.result = (a << (b % 8)) % 256;
      6: e.result = a >> (b % 8);
      default: e.result = a;
    endcase
    e.zero = (e.result == 0);
    return e;
  endfunction

  // Monitor: record accepted beats, compare delivered beats, check hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'({out_result, out_carry, out_overflow, out_zero}), 64'(prev_word));
      end
      if (out_valid && out_ready) begin
        model_done = (model_done + 1) % 65536;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          exp_t e;
          logic [7:0] r8;
          e  = exp_q.pop_front();
          r8 = 8'(e.result);
          check("beat", 64'({out_result, out_carry, out_overflow, out_zero}),
                64'({r8, e.carry, e.ovf, e.zero}));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_result, out_carry, out_overflow, out_zero};
      if (in_valid && in_ready) exp_q.push_back(model(int'(in_op), int'(in_a), int'(in_b)));
    end
  end

  // Random backpressure, active only when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input int op, input int a, input int b);
    int n;
    in_op = 3'(op); in_a = 8'(a); in_b = 8'(b); in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        check("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done_count", 64'(done_count), 64'd0);
    check("rst_data", 64'({out_result, out_carry, out_overflow, out_zero}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // Latency: accepted at edge N, valid after edge N+1.
    @(posedge clk);
    #1;
    in_op = 3'd0; in_a = 8'hFF; in_b = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_on_time", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Directed corner operands.
    send(0, 'h7F, 'h01);
    send(1, 'h03, 'h05);
    send(5, 'h81, 'h09);
    send(6, 'h81, 'h09);
    send(1, 'h80, 'h01);
    send(1, 'h42, 'h42);
    send(2, 'hF0, 'h3C);
    send(3, 'h0F, 'h30);
    send(4, 'hAA, 'hAA);
    send(7, 'h5A, 'hFF);
    drain();

    // Backpressure: fill, verify stall, release and expect a gapless stream.
    out_ready = 1'b0;
    send(0, 1, 2);
    send(1, 9, 4);
    in_op = 3'd4; in_a = 8'h33; in_b = 8'h0F; in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    fork
      begin
        send(4, 'h33, 'h0F);
        send(5, 'h01, 'h03);
        send(7, 'hC3, 'h00);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_no_gap", 64'(out_valid), 64'd1);
        end
      end
    join
    drain();

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b0;
    send(0, 'h10, 'h20);
    send(3, 'h01, 'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_done_count", 64'(done_count), 64'd0);
    check("mid_rst_data", 64'({out_result, out_carry, out_overflow, out_zero}), 64'd0);
    exp_q.delete();
    model_done = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(0, 'h80, 'h80);
    send(6, 'hFF, 'h07);
    drain();
    check("post_rst_count", 64'(done_count), 64'd2);

    // Random traffic with 50% valid and 50% ready.
    rnd_ready = 1;
    for (int unsigned k = 0; k < 10000; k++) begin
      while ($urandom_range(0, 1) == 1) begin
        in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
        @(posedge clk);
        #1;
      end
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    rnd_ready = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("done_count_model", 64'(done_count), 64'(model_done));
    check("done_count_total", 64'(done_count), 64'((10000 + 2) % 65536));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
